dmem: RTL and testbench
=======================

DMEM -- requirements
Module: dmem

Interface
REQ-001 Parameter MEM_SIZE, default 1024, SHALL give the memory capacity in bytes; it is a power of two and at least 4.
REQ-002 i_clk  input  1  SHALL be the single clock; all writes occur on its rising edge.
REQ-003 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_we  input  1  SHALL be the write enable.
REQ-005 i_addr  input  XLEN  SHALL be the byte address.
REQ-006 i_wdata  input  XLEN  SHALL be the write data, little-endian lanes.
REQ-007 i_wstrb  input  XLEN/BYTE_WIDTH (4)  SHALL be the per-byte write strobe; bit i selects i_wdata[8i+7:8i].
REQ-008 o_rdata  output  XLEN  SHALL be the read data.

Function
REQ-009 Storage SHALL be MEM_SIZE/4 words of 32 bits, each organised as four byte lanes.
REQ-010 Word index SHALL be i_addr[log2(MEM_SIZE)-1:2]; i_addr[1:0] and bits at or above log2(MEM_SIZE) SHALL be ignored, so out-of-range addresses alias and wrap.
REQ-011 On a rising i_clk with i_we=1 and i_rst_n=1, lane i of the addressed word SHALL take i_wdata[8i+7:8i] for every i with i_wstrb[i]=1.
REQ-012 Lanes with i_wstrb[i]=0 SHALL keep their previous value.
REQ-013 i_we=1 with i_wstrb=0 SHALL leave memory unchanged.
REQ-014 i_we=0 SHALL leave memory unchanged regardless of i_wstrb.
REQ-015 Reads SHALL be combinational: o_rdata is the full addressed word, with zero clock latency after an i_addr change.
REQ-016 After a write edge, o_rdata SHALL reflect the newly written bytes in the same cycle, with no extra clock needed.
REQ-017 Lane i SHALL map to byte address 4*word+i (little-endian).
REQ-018 Sign or zero extension and sub-word lane alignment are out of scope; the datapath performs them.
REQ-019 No misalignment or out-of-range error SHALL be signalled.

Reset
REQ-020 While i_rst_n=0, every memory byte SHALL be cleared to 0x00 asynchronously, and writes SHALL be blocked.
REQ-021 o_rdata SHALL read 0x00000000 for any address during reset and after reset until that word is written.
REQ-022 Bytes never written since reset SHALL read 0x00, so partial writes show zero in the unwritten lanes.
REQ-023 Writes SHALL resume on the first rising i_clk after i_rst_n deasserts.

Structure
REQ-024 XLEN (32) and BYTE_WIDTH (8) SHALL come from the shared package cotm32_pkg; the module SHALL NOT define local copies.
REQ-025 Storage SHALL be a flat array of XLEN-bit words with a per-lane write loop.
REQ-026 No sub-module is required.

Verification (MEM_SIZE=16)
REQ-027 Full-word write: addr=0x0, wdata=0x11223344, wstrb=1111, we=1 for one edge, then we=0 -> rdata=0x11223344 at addr 0x0.
REQ-028 Halfword write to a reset word: addr=0x4, wdata=0xAABBCCDD, wstrb=0011 -> rdata at 0x4 = 0x0000CCDD.
REQ-029 Byte write: addr=0x8, wdata=0x12345678, wstrb=0001 -> rdata at 0x8 = 0x00000078.
REQ-030 Partial overwrite with same-cycle visibility: after REQ-027, addr=0x0, wdata=0x66778899, wstrb=0011, one edge -> rdata=0x11228899 immediately after the edge.
REQ-031 Write suppression and aliasing: we=0 with wstrb=1111 leaves data unchanged; a write to addr=0x10 SHALL update word 0, and addr=0x3 SHALL read word 0.
REQ-032 Asynchronous reset: assert i_rst_n=0 mid-cycle -> rdata=0x00000000 at every address without a clock edge; a write attempted during reset is ignored.

Source files
------------

// File: rtl/cotm32_pkg.sv
// Shared core-wide constants for the cotm32 datapath.
// Every block sizes its buses from here rather than keeping private copies.
package cotm32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned NUM_LANES  = XLEN / BYTE_WIDTH;

endpackage

// File: rtl/dmem.sv
// Byte-strobed data memory: combinational read, lane-masked write on the rising clock,
// and an asynchronous active-low reset that clears every byte.
module dmem
  import cotm32_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [XLEN-1:0]       i_addr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [NUM_LANES-1:0]  i_wstrb,
  output logic [XLEN-1:0]       o_rdata
);

  localparam int unsigned NumWords = MEM_SIZE / 4;
  localparam int unsigned AddrW    = $clog2(MEM_SIZE);
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;

  logic [XLEN-1:0] r_mem [NumWords];
  logic [IdxW-1:0] w_idx;
  logic [XLEN-1:0] w_unused_addr;

  // Byte offset and bits above the array size are dropped, so high addresses wrap.
  generate
    if (NumWords > 1) begin : g_idx
      assign w_idx = i_addr[AddrW-1:2];
    end else begin : g_idx_single
      assign w_idx = '0;
    end
  endgenerate

  assign w_unused_addr = i_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned w = 0; w < NumWords; w++) begin
        r_mem[w] <= '0;
      end
    end else if (i_we) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (i_wstrb[l]) begin
          r_mem[w_idx][l*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign o_rdata = r_mem[w_idx];

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem with a 16-byte (4-word) array.
module tb_dmem;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  int unsigned n_checks;
  int unsigned n_fail;

  dmem #(
    .MEM_SIZE(16)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_we   (we),
    .i_addr (addr),
    .i_wdata(wdata),
    .i_wstrb(wstrb),
    .o_rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present a transaction after the falling edge, take one rising edge, then drop we.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic en);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wstrb = s;
    we    = en;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    wstrb    = '0;

    #2;
    check_eq("reset_rd0", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd($sformatf("post_reset_w%0d", i), 32'(i * 4), 32'h0);
    end

    wr(32'h0, 32'h1122_3344, 4'b1111, 1'b1);
    check_eq("full_word", rdata, 32'h1122_3344);

    wr(32'h4, 32'hAABB_CCDD, 4'b0011, 1'b1);
    check_eq("halfword", rdata, 32'h0000_CCDD);

    wr(32'h8, 32'h1234_5678, 4'b0001, 1'b1);
    check_eq("byte0", rdata, 32'h0000_0078);

    // Addr still 0 after the edge: the merged word must already be visible.
    wr(32'h0, 32'h6677_8899, 4'b0011, 1'b1);
    check_eq("partial_same_cycle", rdata, 32'h1122_8899);
    rd("word1_undisturbed", 32'h4, 32'h0000_CCDD);
    rd("word2_undisturbed", 32'h8, 32'h0000_0078);

    wr(32'h0, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    check_eq("we0_suppress", rdata, 32'h1122_8899);

    wr(32'h0, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    check_eq("strb0_suppress", rdata, 32'h1122_8899);

    wr(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    rd("alias_0x0", 32'h0, 32'hDEAD_BEEF);
    rd("alias_0x3", 32'h3, 32'hDEAD_BEEF);
    rd("alias_0x13", 32'h13, 32'hDEAD_BEEF);

    wr(32'hC, 32'h00AB_0000, 4'b0100, 1'b1);
    check_eq("lane2", rdata, 32'h00AB_0000);
    rd("lane2_0xE", 32'hE, 32'h00AB_0000);
    wr(32'h8, 32'hCD00_0000, 4'b1000, 1'b1);
    check_eq("lane3_merge", rdata, 32'hCD00_0078);

    // Assert reset between edges; contents must clear with no clock.
    @(posedge clk);
    #2;
    addr  = 32'h0;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_w0", rdata, 32'h0);
    rd("async_rst_w1", 32'h4, 32'h0);
    rd("async_rst_w2", 32'h8, 32'h0);
    rd("async_rst_w3", 32'hC, 32'h0);

    wr(32'h4, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    check_eq("write_blocked_in_reset", rdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("after_release", rdata, 32'h0);
    wr(32'h4, 32'h0000_5A5A, 4'b0011, 1'b1);
    check_eq("first_write_after_reset", rdata, 32'h0000_5A5A);
    rd("other_word_still_zero", 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
